// File: rtl/win_buf_seq.sv
// rtl/win_buf_seq.sv - WIN x WIN window-buffer fill sequencer reading a word image from SRAM
// Optional WB_TIMEOUT_EN: abort the frame with an err pulse when ram_ack misses TIMEOUT cycles.
module win_buf_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WIN     = 3,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  output logic                    ram_req,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic                    ram_ack,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic                    wb_clear,
  output logic                    wb_shift,
  output logic                    wb_w_en,
  output logic [$clog2(WIN)-1:0]  wb_row,
  output logic [$clog2(WIN)-1:0]  wb_col,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int IW   = $clog2(WIN);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int BPW  = DATA_W / 8;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  if (WIN < 2 || WIN > 8 || IMG_W < WIN || IMG_H < WIN || TIMEOUT < 1 || TO_W < 1) begin : g_param_check
    $error("win_buf_seq: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAIT_ACK, S_WRITE, S_WIN_OUT, S_SLIDE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [IW-1:0]     lr_q, lr_d, lc_q, lc_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef WB_TIMEOUT_EN
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_q  <= '0;
      col_q  <= '0;
      lr_q   <= '0;
      lc_q   <= '0;
      base_q <= '0;
      addr_q <= '0;
      data_q <= '0;
`ifdef WB_TIMEOUT_EN
      cnt_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      lr_q   <= lr_d;
      lc_q   <= lc_d;
      base_q <= base_d;
      addr_q <= addr_d;
      data_q <= data_d;
`ifdef WB_TIMEOUT_EN
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lr_d    = lr_q;
    lc_d    = lc_q;
    base_d  = base_q;
    data_d  = data_q;
`ifdef WB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = start_addr;
          row_d   = '0;
          col_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        lr_d    = '0;
        lc_d    = '0;
        state_d = S_REQ;
      end
      // An ack arriving together with the rising req is taken right away.
      S_REQ: begin
        if (ram_ack) begin
          data_d  = ram_rdata;
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_ACK;
`ifdef WB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT_ACK: begin
        if (ram_ack) begin
          data_d  = ram_rdata;
          state_d = S_WRITE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + TO_W'(1);
        end
`endif
      end
      S_WRITE: begin
        if (lr_q != IW'(WIN - 1)) begin
          lr_d    = lr_q + IW'(1);
          state_d = S_REQ;
        end else if (lc_q != IW'(WIN - 1)) begin
          lr_d    = '0;
          lc_d    = lc_q + IW'(1);
          state_d = S_REQ;
        end else begin
          state_d = S_WIN_OUT;
        end
      end
      S_WIN_OUT: begin
        if (win_ready) begin
          if (col_q < CW'(IMG_W - WIN)) begin
            col_d   = col_q + CW'(1);
            state_d = S_SLIDE;
          end else if (row_q < RW'(IMG_H - WIN)) begin
            row_d   = row_q + RW'(1);
            col_d   = '0;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      // Only the newly exposed right-hand column needs fetching after a shift.
      S_SLIDE: begin
        lr_d    = '0;
        lc_d    = IW'(WIN - 1);
        state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_d == S_REQ) begin
      addr_d = base_q + ((ADDR_W'(row_q) + ADDR_W'(lr_d)) * ADDR_W'(IMG_W)
                         + ADDR_W'(col_q) + ADDR_W'(lc_d)) * ADDR_W'(BPW);
    end
  end

  always_comb begin
    ram_req   = (state_q == S_REQ) || (state_q == S_WAIT_ACK);
    wb_clear  = (state_q == S_CLEAR);
    wb_shift  = (state_q == S_SLIDE);
    wb_w_en   = (state_q == S_WRITE);
    win_valid = (state_q == S_WIN_OUT);
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
`ifdef WB_TIMEOUT_EN
    err       = err_q;
`else
    err       = 1'b0;
`endif
  end

  assign ram_addr = addr_q;
  assign wb_row   = lr_q;
  assign wb_col   = lc_q;
  assign wb_data  = data_q;

endmodule

// File: tb/tb_win_buf_seq.sv
// tb/tb_win_buf_seq.sv - self-checking bench for win_buf_seq (WIN=3, 5x4 image)
module tb_win_buf_seq;

  localparam int ADDR_W = 32, DATA_W = 32, WIN = 3, IMG_W = 5, IMG_H = 4, TIMEOUT = 8;
  localparam int IW = $clog2(WIN);
  localparam int K_CLR = 0, K_SH = 1, K_WR = 2, K_WIN = 3, K_DONE = 4;

  logic clk, n_rst, start, ram_req, ram_ack, wb_clear, wb_shift, wb_w_en;
  logic win_valid, win_ready, busy, done, err;
  logic [ADDR_W-1:0] start_addr, ram_addr;
  logic [DATA_W-1:0] ram_rdata, wb_data;
  logic [IW-1:0]     wb_row, wb_col;

  typedef struct { int kind; int row; int col; logic [31:0] addr; } ev_t;
  ev_t exp_q[$];
  int  obs_kind[$];
  logic [31:0] obs_addr[$];
  int  obs_col[$];
  int  checks = 0, failures = 0;
  int  n_win, n_wr, n_clr, n_sh, n_done;
  int  ack_delay = 0, wcnt = 0;
  bit  ack_never = 0, mon_en = 0;
  logic [31:0] lit_addr [12] = '{32'h1000, 32'h1014, 32'h1028, 32'h1004, 32'h1018, 32'h102C,
                                 32'h1008, 32'h101C, 32'h1030, 32'h100C, 32'h1020, 32'h1034};

  win_buf_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WIN(WIN), .IMG_W(IMG_W),
                .IMG_H(IMG_H), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .start_addr(start_addr),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .wb_clear(wb_clear), .wb_shift(wb_shift), .wb_w_en(wb_w_en), .wb_row(wb_row),
    .wb_col(wb_col), .wb_data(wb_data), .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected event stream for one frame, derived from the raster window walk.
  task automatic build_exp(input logic [31:0] base);
    ev_t e;
    exp_q.delete();
    for (int r = 0; r <= IMG_H - WIN; r++) begin
      for (int c = 0; c <= IMG_W - WIN; c++) begin
        e = '{kind: (c == 0) ? K_CLR : K_SH, row: 0, col: 0, addr: 0};
        exp_q.push_back(e);
        for (int lc = (c == 0) ? 0 : WIN - 1; lc < WIN; lc++)
          for (int lr = 0; lr < WIN; lr++) begin
            e = '{kind: K_WR, row: lr, col: lc,
                  addr: base + 32'(((r + lr) * IMG_W + c + lc) * (DATA_W / 8))};
            exp_q.push_back(e);
          end
        e = '{kind: K_WIN, row: 0, col: 0, addr: 0};
        exp_q.push_back(e);
      end
    end
    e = '{kind: K_DONE, row: 0, col: 0, addr: 0};
    exp_q.push_back(e);
  endtask

  // SRAM responder: ack after ack_delay req cycles (0 = same cycle req rises).
  initial begin
    ram_ack = 1'b0;
    ram_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      if (ram_req && !ack_never && wcnt == ack_delay) begin
        ram_ack = 1'b1; ram_rdata = memf(ram_addr); wcnt = 0;
      end else begin
        ram_ack = 1'b0; ram_rdata = 32'hDEAD_BEEF; wcnt = ram_req ? wcnt + 1 : 0;
      end
    end
  end

  // Compare process: every cycle while a frame is being monitored.
  initial begin
    logic p_req, p_ack;
    logic [31:0] p_addr;
    int kind;
    ev_t e;
    p_req = 0; p_ack = 0; p_addr = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("strobe_exclusive", 64'(int'(wb_clear) + int'(wb_shift) + int'(wb_w_en) <= 1), 64'(1));
        chk("err_quiet", 64'(err), 64'(0));
        if (p_req && !p_ack) begin
          chk("req_held", 64'(ram_req), 64'(1));
          chk("addr_stable", 64'(ram_addr), 64'(p_addr));
        end
        chk("write_after_ack", 64'(wb_w_en), 64'(p_req && p_ack));
        kind = wb_clear ? K_CLR : wb_shift ? K_SH : wb_w_en ? K_WR :
               (win_valid && win_ready) ? K_WIN : done ? K_DONE : -1;
        if (kind >= 0) begin
          obs_kind.push_back(kind);
          case (kind)
            K_CLR:  n_clr++;
            K_SH:   n_sh++;
            K_WR:   begin n_wr++; obs_addr.push_back(ram_addr); obs_col.push_back(int'(wb_col)); end
            K_WIN:  n_win++;
            default: begin n_done++; chk("busy_at_done", 64'(busy), 64'(0)); end
          endcase
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (kind == K_WR && e.kind == K_WR) begin
              chk("wb_row", 64'(wb_row), 64'(e.row));
              chk("wb_col", 64'(wb_col), 64'(e.col));
              chk("ram_addr", 64'(ram_addr), 64'(e.addr));
              chk("wb_data", 64'(wb_data), 64'(memf(e.addr)));
            end
          end
        end
        p_req = ram_req; p_ack = ram_ack; p_addr = ram_addr;
      end else begin
        p_req = 0; p_ack = 0; p_addr = 0;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] base);
    @(posedge clk); #1;
    start = 1'b1; start_addr = base;
    @(posedge clk); #1;
    start = 1'b0; start_addr = '0;
  endtask

  task automatic run_frame(input logic [31:0] base, input int dly, input bit bp, input bit busy_start);
    int n;
    build_exp(base);
    n_win = 0; n_wr = 0; n_clr = 0; n_sh = 0; n_done = 0;
    obs_kind.delete(); obs_addr.delete(); obs_col.delete();
    ack_delay = dly;
    win_ready = !bp;
    @(posedge clk); #1;
    mon_en = 1'b1;
    pulse_start(base);
    chk("busy_after_start", 64'(busy), 64'(1));
    if (busy_start) begin
      repeat (20) @(posedge clk);
      pulse_start(32'hFFFF_0000);
    end
    if (bp) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!win_valid && n < 500);
      chk("bp_window_seen", 64'(win_valid), 64'(1));
      for (int i = 0; i < 10; i++) begin
        chk("bp_valid_held", 64'(win_valid), 64'(1));
        chk("bp_no_req", 64'(ram_req), 64'(0));
        chk("bp_no_write", 64'(wb_w_en), 64'(0));
        @(negedge clk);
      end
      @(posedge clk); #1;
      win_ready = 1'b1;
    end
    n = 0;
    while (n_done == 0 && n < 5000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("busy_after_done", 64'(busy), 64'(0));
    chk("events_left", 64'(exp_q.size()), 64'(0));
    chk("n_windows", 64'(n_win), 64'(6));
    chk("n_writes", 64'(n_wr), 64'(30));
    chk("n_clears", 64'(n_clr), 64'(2));
    chk("n_shifts", 64'(n_sh), 64'(4));
    chk("n_done", 64'(n_done), 64'(1));
    win_ready = 1'b1;
    ack_delay = 0;
  endtask

  initial begin
    int n;
    n_rst = 1'b0; start = 1'b0; start_addr = '0; win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({ram_req, wb_clear, wb_shift, wb_w_en, wb_row, wb_col, win_valid, busy, done, err}), 64'(0));
    chk("reset_addr", 64'(ram_addr), 64'(0));
    chk("reset_data", 64'(wb_data), 64'(0));
    n_rst = 1'b1;

    // Asynchronous reset while waiting for an ack.
    ack_never = 1'b1;
    pulse_start(32'h2000);
    n = 0;
    do begin @(negedge clk); n++; end while (!ram_req && n < 10);
    repeat (3) @(negedge clk);
    chk("wait_req_held", 64'(ram_req), 64'(1));
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({ram_req, wb_clear, wb_shift, wb_w_en, wb_row, wb_col, win_valid, busy, done, err}), 64'(0));
    chk("async_reset_addr", 64'(ram_addr), 64'(0));
    @(posedge clk); #1;
    n_rst = 1'b1;
    ack_never = 1'b0;
    chk("idle_after_reset", 64'(busy), 64'(0));

    // Frame 1: immediate ack, no backpressure; pin the first 12 fetches.
    run_frame(32'h1000, 0, 1'b0, 1'b0);
    if (obs_addr.size() < 12 || obs_kind.size() < 13) begin
      chk("frame1_log_size", 64'(obs_addr.size()), 64'(30));
    end else begin
      for (int i = 0; i < 12; i++) chk("lit_addr", 64'(obs_addr[i]), 64'(lit_addr[i]));
      for (int i = 9; i < 12; i++) chk("lit_slide_col", 64'(obs_col[i]), 64'(2));
      chk("lit_first_clear", 64'(obs_kind[0]), 64'(K_CLR));
      chk("lit_win_after_9", 64'(obs_kind[10]), 64'(K_WIN));
      chk("lit_shift", 64'(obs_kind[11]), 64'(K_SH));
    end

    // Frame 2: delayed ack, backpressure on the first window, start while busy.
    run_frame(32'h0004_0000, 5, 1'b1, 1'b1);

`ifdef WB_TIMEOUT_EN
    begin
      bit saw_done;
      saw_done = 0;
      ack_never = 1'b1;
      pulse_start(32'h3000);
      n = 0;
      do begin @(negedge clk); n++; end while (!ram_req && n < 10);
      n = 0;
      do begin @(negedge clk); n++; saw_done |= done; end while (!err && n < 40);
      chk("timeout_err", 64'(err), 64'(1));
      chk("timeout_latency", 64'(n), 64'(9));
      chk("timeout_busy", 64'(busy), 64'(0));
      chk("timeout_req", 64'(ram_req), 64'(0));
      @(negedge clk);
      saw_done |= done;
      chk("timeout_err_pulse", 64'(err), 64'(0));
      chk("timeout_no_done", 64'(saw_done), 64'(0));
      ack_never = 1'b0;
      run_frame(32'h1000, 0, 1'b0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
